// File: rtl/core_insn_loader_pkg.sv
// core_insn_loader_pkg
// Shared constants and FSM encoding for the per-core instruction loader.
// The default sizes match the scheduler's range definitions:
//   INSN_WIDTH_DEF, REG_WIDTH_DEF, NUM_INSN_DEF
//   loader_state_e : READY = 0, RUN = 1
package core_insn_loader_pkg;

    localparam int INSN_WIDTH_DEF = 16;
    localparam int REG_WIDTH_DEF  = 8;
    localparam int NUM_INSN_DEF   = 16;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_RUN   = 1'b1
    } loader_state_e;

endpackage

// File: rtl/core_insn_loader_insn_buf_ram.sv
// insn_buf_ram
// Local instruction buffer: DEPTH x WIDTH, one synchronous write port and
// one registered read port. Only the read register is reset; the array is
// left uninitialised so it can map onto plain memory.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (read register only)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr      : read request, data appears on o_rdata next cycle
//   o_rdata           : registered read data (holds when i_re is low)
module insn_buf_ram
    import core_insn_loader_pkg::*;
#(
    parameter int DEPTH = NUM_INSN_DEF,
    parameter int WIDTH = INSN_WIDTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/core_insn_loader.sv
// core_insn_loader
// Per-core front end behind the task scheduler. Captures the broadcast
// instruction frame into a local buffer while idle, latches the R0 initial
// value, owns the READY/RUN handshake and serves registered instruction
// fetches while running.
// Optional feature: define LOADER_PERF_CNT_EN to add the o_busy_cycles
// counter (saturating count of RUN cycles, cleared only by reset).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_insn_load_counter/i_insn_data : scheduler frame broadcast (data lags index by 1)
//   i_start / i_core_done      : handshake pulses
//   i_init_r0_en / i_init_r0   : R0 initial value capture
//   i_fetch_req / i_fetch_pc   : fetch request from the core pipeline
//   o_ready / o_run            : idle / executing
//   o_fetch_valid / o_fetch_insn : fetch response, one cycle after request
//   o_r0_value / o_r0_load     : latched R0 value and load pulse
//   o_start_err                : pulse for a start received while running
//   o_busy_cycles              : RUN cycle counter (LOADER_PERF_CNT_EN only)
module core_insn_loader
    import core_insn_loader_pkg::*;
#(
    parameter int NUM_INSN   = NUM_INSN_DEF,
    parameter int INSN_WIDTH = INSN_WIDTH_DEF,
    parameter int REG_WIDTH  = REG_WIDTH_DEF,
    parameter int CNT_WIDTH  = $clog2(NUM_INSN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CNT_WIDTH-1:0]  i_insn_load_counter,
    input  logic [INSN_WIDTH-1:0] i_insn_data,
    input  logic                  i_start,
    input  logic                  i_init_r0_en,
    input  logic [REG_WIDTH-1:0]  i_init_r0,
    input  logic                  i_core_done,
    input  logic                  i_fetch_req,
    input  logic [CNT_WIDTH-1:0]  i_fetch_pc,
`ifdef LOADER_PERF_CNT_EN
    output logic [31:0]           o_busy_cycles,
`endif
    output logic                  o_ready,
    output logic                  o_run,
    output logic                  o_fetch_valid,
    output logic [INSN_WIDTH-1:0] o_fetch_insn,
    output logic [REG_WIDTH-1:0]  o_r0_value,
    output logic                  o_r0_load,
    output logic                  o_start_err
);

    loader_state_e r_state, w_state_nxt;

    logic [CNT_WIDTH-1:0] r_cnt_d;
    logic [REG_WIDTH-1:0] r_r0_value;
    logic                 r_r0_pend;
    logic                 r_r0_load;
    logic                 r_start_err;
    logic                 r_fetch_valid;

    logic w_buf_we;
    logic w_fetch_acc;
    logic w_r0_cap;
    logic w_go;
    logic w_start_err;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // start wins in READY, core_done wins in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_we    = 1'b0;
        w_fetch_acc = 1'b0;
        w_r0_cap    = 1'b0;
        w_go        = 1'b0;
        w_start_err = 1'b0;
        case (r_state)
            ST_READY: begin
                w_buf_we = ~reset;
                w_r0_cap = i_init_r0_en;
                if (i_start) begin
                    w_go        = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_fetch_acc = i_fetch_req;
                w_start_err = i_start;
                if (i_core_done) begin
                    w_state_nxt = ST_READY;
                end
            end
            default: w_state_nxt = ST_READY;
        endcase
    end

    // ---------------- frame capture ----------------
    // Scheduler data is registered, so the word arriving now belongs to
    // the index seen last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_d <= CNT_WIDTH'(NUM_INSN - 1);
        end else begin
            r_cnt_d <= i_insn_load_counter;
        end
    end

    insn_buf_ram #(
        .DEPTH (NUM_INSN),
        .WIDTH (INSN_WIDTH),
        .AW    (CNT_WIDTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_buf_we),
        .i_waddr (r_cnt_d),
        .i_wdata (i_insn_data),
        .i_re    (w_fetch_acc),
        .i_raddr (i_fetch_pc),
        .o_rdata (o_fetch_insn)
    );

    // ---------------- R0 / pulses / fetch valid ----------------
    // A capture in the same cycle as start still produces the load pulse,
    // so the pulse condition looks at the incoming enable as well as the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r0_value    <= '0;
            r_r0_pend     <= 1'b0;
            r_r0_load     <= 1'b0;
            r_start_err   <= 1'b0;
            r_fetch_valid <= 1'b0;
        end else begin
            if (w_r0_cap) begin
                r_r0_value <= i_init_r0;
            end
            if (w_go) begin
                r_r0_pend <= 1'b0;
            end else if (w_r0_cap) begin
                r_r0_pend <= 1'b1;
            end
            r_r0_load     <= w_go & (r_r0_pend | w_r0_cap);
            r_start_err   <= w_start_err;
            r_fetch_valid <= w_fetch_acc;
        end
    end

`ifdef LOADER_PERF_CNT_EN
    logic [31:0] r_busy_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_cycles <= '0;
        end else if (r_state == ST_RUN && r_busy_cycles != 32'hFFFF_FFFF) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign o_busy_cycles = r_busy_cycles;
`endif

    assign o_ready       = (r_state == ST_READY);
    assign o_run         = ~o_ready;
    assign o_fetch_valid = r_fetch_valid;
    assign o_r0_value    = r_r0_value;
    assign o_r0_load     = r_r0_load;
    assign o_start_err   = r_start_err;

endmodule

// File: tb/tb_core_insn_loader.sv
// Testbench for core_insn_loader: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the loader rules.
module tb_core_insn_loader;

    localparam int N  = 16;
    localparam int IW = 16;
    localparam int RW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] counter;
    logic [IW-1:0] data;
    logic          start, init_r0_en, core_done, fetch_req;
    logic [RW-1:0] init_r0;
    logic [CW-1:0] fetch_pc;
    logic          ready, run, fetch_valid, r0_load, start_err;
    logic [IW-1:0] fetch_insn;
    logic [RW-1:0] r0_value;
`ifdef LOADER_PERF_CNT_EN
    logic [31:0]   busy_cycles;
`endif

    always #5 clk = ~clk;

    core_insn_loader #(.NUM_INSN(N), .INSN_WIDTH(IW), .REG_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_insn_load_counter (counter),
        .i_insn_data         (data),
        .i_start             (start),
        .i_init_r0_en        (init_r0_en),
        .i_init_r0           (init_r0),
        .i_core_done         (core_done),
        .i_fetch_req         (fetch_req),
        .i_fetch_pc          (fetch_pc),
`ifdef LOADER_PERF_CNT_EN
        .o_busy_cycles       (busy_cycles),
`endif
        .o_ready             (ready),
        .o_run               (run),
        .o_fetch_valid       (fetch_valid),
        .o_fetch_insn        (fetch_insn),
        .o_r0_value          (r0_value),
        .o_r0_load           (r0_load),
        .o_start_err         (start_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    logic          m_run;
    logic [CW-1:0] m_prev_idx;
    logic [IW-1:0] m_buf   [N];
    bit            m_known [N];
    logic [RW-1:0] m_r0;
    bit            m_pend;
    logic          e_fv, e_r0_load, e_err;
    logic [IW-1:0] e_insn;
    bit            e_insn_known;
    longint        m_busy;
    logic [IW-1:0] frame [N];

    // Applies one clock of the loader rules to the model, then advances
    // the DUT one edge and settles.
    task automatic tick();
        bit was_run;
        was_run = m_run;
        if (reset) begin
            m_run = 0; m_prev_idx = CW'(N - 1); m_r0 = '0; m_pend = 0;
            e_fv = 0; e_r0_load = 0; e_err = 0; e_insn = '0; e_insn_known = 1;
            m_busy = 0;
        end else begin
            e_err     = was_run && start;
            e_fv      = was_run && fetch_req;
            e_r0_load = !was_run && start && (m_pend || init_r0_en);
            if (was_run && fetch_req) begin
                e_insn = m_buf[fetch_pc]; e_insn_known = m_known[fetch_pc];
            end
            if (!was_run) begin
                m_buf[m_prev_idx] = data; m_known[m_prev_idx] = 1;
                if (init_r0_en) begin m_r0 = init_r0; m_pend = 1; end
                if (start) m_pend = 0;
            end
            if (was_run && m_busy < 64'hFFFF_FFFF) m_busy++;
            m_run      = was_run ? !core_done : start;
            m_prev_idx = counter;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        start = 0; core_done = 0; init_r0_en = 0; fetch_req = 0;
    endtask

    // Scheduler-style frame broadcast: index i, its data one cycle later,
    // index held at N-1 afterwards.
    task automatic load_frame(input bit rnd);
        for (int i = 0; i < N; i++) frame[i] = rnd ? IW'($urandom) : 16'hA000 + IW'(i);
        for (int i = 0; i <= N; i++) begin
            counter = (i < N) ? CW'(i) : CW'(N - 1);
            if (i > 0) data = frame[i-1];
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1; idle_inputs(); counter = CW'(N - 1); data = '0; init_r0 = '0; fetch_pc = '0;
        m_run = 1;
        for (int i = 0; i < N; i++) m_known[i] = 0;
        tick(); tick();
        n_total++;
        if ({ready, run, fetch_valid, r0_load, start_err} !== 5'b10000)
            $display("FAIL reset_ctrl got %b want 10000", {ready, run, fetch_valid, r0_load, start_err});
        else n_pass++;
        n_total++;
        if (fetch_insn !== '0 || r0_value !== '0)
            $display("FAIL reset_data got insn=%h r0=%h want 0/0", fetch_insn, r0_value);
        else n_pass++;
        reset = 0;
    endtask

    task automatic test_load_fetch();
        load_frame(0);
        start = 1; tick(); start = 0;
        n_total++;
        if (ready !== 1'b0 || run !== 1'b1) $display("FAIL lf_start got ready=%b run=%b want 0/1", ready, run);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            fetch_req = 1; fetch_pc = CW'(i); tick();
            n_total++;
            if (fetch_valid !== 1'b1 || fetch_insn !== 16'hA000 + IW'(i))
                $display("FAIL lf_fetch%0d got v=%b %h want 1 %h", i, fetch_valid, fetch_insn, 16'hA000 + IW'(i));
            else n_pass++;
        end
        fetch_req = 0; tick();
        n_total++;
        if (fetch_valid !== 1'b0) $display("FAIL lf_novalid got %b want 0", fetch_valid);
        else n_pass++;
        core_done = 1; tick(); core_done = 0;
    endtask

    task automatic test_handshake();
        for (int c = 0; c < 10; c++) tick();
        start = 1; tick(); start = 0;
        n_total++;
        if (ready !== 1'b0) $display("FAIL hs_start got ready=%b want 0", ready);
        else n_pass++;
        for (int c = 0; c < 9; c++) tick();
        n_total++;
        if (ready !== 1'b0) $display("FAIL hs_hold got ready=%b want 0", ready);
        else n_pass++;
        core_done = 1; tick(); core_done = 0;
        n_total++;
        if (ready !== 1'b1) $display("FAIL hs_done got ready=%b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_r0();
        init_r0_en = 1; init_r0 = 8'h5C; tick(); init_r0_en = 0; init_r0 = 8'h11;
        tick();
        start = 1; tick(); start = 0;
        n_total++;
        if (r0_value !== 8'h5C || r0_load !== 1'b1)
            $display("FAIL r0_pulse got val=%h load=%b want 5c/1", r0_value, r0_load);
        else n_pass++;
        tick();
        n_total++;
        if (r0_load !== 1'b0) $display("FAIL r0_single got load=%b want 0", r0_load);
        else n_pass++;
        core_done = 1; tick(); core_done = 0; tick();
        start = 1; tick(); start = 0;
        n_total++;
        if (r0_load !== 1'b0 || r0_value !== 8'h5C)
            $display("FAIL r0_nopend got load=%b val=%h want 0/5c", r0_load, r0_value);
        else n_pass++;
        core_done = 1; tick(); core_done = 0;
        // capture in the same cycle as start
        init_r0_en = 1; init_r0 = 8'hA7; start = 1; tick(); init_r0_en = 0; start = 0;
        n_total++;
        if (r0_load !== 1'b1 || r0_value !== 8'hA7)
            $display("FAIL r0_same got load=%b val=%h want 1/a7", r0_load, r0_value);
        else n_pass++;
        core_done = 1; tick(); core_done = 0;
    endtask

    task automatic test_write_protect();
        logic [CW-1:0] sv_cnt;
        logic [IW-1:0] sv_data;
        sv_cnt = counter; sv_data = data;
        start = 1; tick(); start = 0;
        counter = 3; data = 16'hFFFF; tick(); tick(); tick();
        counter = sv_cnt; data = sv_data; tick();
        fetch_req = 1; fetch_pc = 3; tick(); fetch_req = 0;
        n_total++;
        if (fetch_valid !== 1'b1 || fetch_insn !== 16'hA003)
            $display("FAIL wp_fetch got v=%b %h want 1 a003", fetch_valid, fetch_insn);
        else n_pass++;
        core_done = 1; tick(); core_done = 0; tick();
    endtask

    task automatic test_errors();
        start = 1; tick(); start = 0;
        start = 1; tick(); start = 0;
        n_total++;
        if (start_err !== 1'b1 || ready !== 1'b0)
            $display("FAIL err_run got err=%b ready=%b want 1/0", start_err, ready);
        else n_pass++;
        tick();
        n_total++;
        if (start_err !== 1'b0) $display("FAIL err_pulse got %b want 0", start_err);
        else n_pass++;
        start = 1; core_done = 1; tick();
        n_total++;
        if (ready !== 1'b1 || start_err !== 1'b1)
            $display("FAIL coll_run got ready=%b err=%b want 1/1", ready, start_err);
        else n_pass++;
        tick(); start = 0; core_done = 0;
        n_total++;
        if (ready !== 1'b0 || start_err !== 1'b0)
            $display("FAIL coll_ready got ready=%b err=%b want 0/0", ready, start_err);
        else n_pass++;
        core_done = 1; tick(); core_done = 0;
        fetch_req = 1; fetch_pc = 5; tick(); tick(); fetch_req = 0;
        n_total++;
        if (fetch_valid !== 1'b0) $display("FAIL fetch_ready got %b want 0", fetch_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        start = 1; tick(); start = 0;
        fetch_req = 1; fetch_pc = 7; reset = 1; tick(); reset = 0; fetch_req = 0;
        n_total++;
        if (ready !== 1'b1 || fetch_valid !== 1'b0 || r0_value !== '0)
            $display("FAIL rst_run got ready=%b v=%b r0=%h want 1/0/00", ready, fetch_valid, r0_value);
        else n_pass++;
    endtask

    task automatic test_random();
        load_frame(1);
        for (int c = 0; c < 400; c++) begin
            start      = ($urandom_range(9) == 0);
            core_done  = ($urandom_range(9) == 0);
            init_r0_en = ($urandom_range(7) == 0);
            init_r0    = RW'($urandom);
            fetch_req  = $urandom_range(1);
            fetch_pc   = CW'($urandom);
            if ($urandom_range(15) == 0) begin
                counter = CW'($urandom); data = IW'($urandom);
            end
            tick();
            n_total++;
            if ({ready, run, fetch_valid, r0_load, start_err, r0_value} !==
                {!m_run, m_run, e_fv, e_r0_load, e_err, m_r0})
                $display("FAIL rnd_ctrl cyc%0d got %b want %b", c,
                    {ready, run, fetch_valid, r0_load, start_err, r0_value},
                    {!m_run, m_run, e_fv, e_r0_load, e_err, m_r0});
            else n_pass++;
            if (e_insn_known) begin
                n_total++;
                if (fetch_insn !== e_insn) $display("FAIL rnd_insn cyc%0d got %h want %h", c, fetch_insn, e_insn);
                else n_pass++;
            end
        end
        idle_inputs();
        if (m_run) begin core_done = 1; tick(); core_done = 0; end
    endtask

`ifdef LOADER_PERF_CNT_EN
    task automatic test_perf();
        reset = 1; tick(); reset = 0;
        start = 1; tick(); start = 0;
        for (int c = 0; c < 6; c++) tick();
        core_done = 1; tick(); core_done = 0;
        tick(); tick();
        n_total++;
        if (busy_cycles !== 32'd7 || 64'(busy_cycles) != m_busy)
            $display("FAIL perf_busy got %0d want 7 (model %0d)", busy_cycles, m_busy);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_fetch();
        test_handshake();
        test_r0();
        test_write_protect();
        test_errors();
        test_reset_mid_run();
        test_random();
`ifdef LOADER_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/core_insn_loader.md
# core_insn_loader

Per-core front end sitting directly downstream of the task scheduler. It captures the broadcast instruction frame into a local instruction buffer, latches the per-core R0 initial value, and owns the core's READY/RUN handshake. It starts execution on the scheduler's `start` pulse and serves instruction fetches to the core pipeline. One instance per core; its `ready` output is this core's bit of the scheduler's `Ready` vector.

## Interface
- `NUM_INSN`, default 16: instructions per frame; equals the scheduler's load time.
- `INSN_WIDTH`, default 16: instruction width in bits.
- `REG_WIDTH`, default 8: R0 width in bits.
- `CNT_WIDTH`, default `$clog2(NUM_INSN)`: width of the load counter and the PC.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `insn_load_counter` in `CNT_WIDTH`: scheduler load index, broadcast to all cores.
- `insn_data` in `INSN_WIDTH`: broadcast instruction word.
- `start` in 1: this core's `Start` bit; single-cycle pulse.
- `init_r0_en` in 1: this core's `Init_R0_Vect` bit.
- `init_r0` in `REG_WIDTH`: this core's slice of `Init_R0`.
- `core_done` in 1: core finished the task; single-cycle pulse.
- `fetch_req` in 1: core requests an instruction.
- `fetch_pc` in `CNT_WIDTH`: fetch address.
- `ready` out 1: core idle; feeds the scheduler `Ready` bit.
- `run` out 1: core executing; equals `~ready`.
- `fetch_valid` out 1: `fetch_insn` is valid this cycle.
- `fetch_insn` out `INSN_WIDTH`: fetched instruction.
- `r0_value` out `REG_WIDTH`: latched R0 initial value.
- `r0_load` out 1: pulse telling the core to load `r0_value` into R0.
- `start_err` out 1: pulse when `start` arrives while in RUN.
- `busy_cycles` out 32: present only with `LOADER_PERF_CNT_EN`.

## Operation
- Two-state FSM, READY and RUN. Reset state is READY.
- READY → RUN on `start`. RUN → READY on `core_done`.
  - `core_done` in READY is ignored.
  - `start` in RUN is ignored and pulses `start_err`.
- Buffer write: `insn_data` in cycle t+1 belongs to index `insn_load_counter` sampled at cycle t (the scheduler registers its data).
  - The loader keeps a one-cycle delayed copy of the counter, `cnt_d`.
  - Every cycle in READY: `buf[cnt_d] <= insn_data`.
  - No buffer writes occur in RUN.
  - Rewriting the same index with the same data is harmless, so the scheduler holding its counter at `NUM_INSN-1` is safe.
- R0 capture: in READY, `init_r0_en` high latches `init_r0` into `r0_value`. The pending flag is set.
- On the READY → RUN transition, `r0_load` pulses for one cycle if the pending flag is set. The flag is then cleared.
- Fetch: accepted only in RUN.
  - `fetch_req` at cycle t gives `fetch_valid` at t+1, with `fetch_insn = buf[fetch_pc]` (registered read).
  - `fetch_req` in READY is dropped: `fetch_valid` stays low.
- The buffer is not cleared by reset; its contents are undefined until loaded.

## Timing
- Reset values:
  - `ready` = 1, `run` = 0.
  - `fetch_valid` = 0, `fetch_insn` = 0.
  - `r0_value` = 0, `r0_load` = 0.
  - `start_err` = 0, `busy_cycles` = 0.
  - `cnt_d` = `NUM_INSN-1`; pending flag = 0.
- `start` at t → `ready` low and `r0_load` pulse at t+1. First fetch may issue at t+1.
- `core_done` at t → `ready` high at t+1. A buffer write can occur at t+1.
- `start` and `core_done` in the same cycle:
  - In READY, `start` wins and the FSM goes to RUN.
  - In RUN, `core_done` wins and the FSM goes to READY; `start_err` also pulses.
- `init_r0_en` in the same cycle as `start`: the value is latched and `r0_load` still pulses at t+1.
- Reset mid-RUN: the FSM returns to READY next cycle and an in-flight `fetch_valid` is cancelled.

## Configuration
- `LOADER_PERF_CNT_EN` defined:
  - `busy_cycles` increments every cycle in RUN.
  - It saturates at `32'hFFFF_FFFF` and clears only on reset.
- Not defined: the port and the counter are absent, with zero logic.

## Structure
- Shared package/include holds: the `INSN_WIDTH`, `REG_WIDTH` and `NUM_INSN` constants (matching the scheduler's range defines), and the FSM state encoding (READY=0, RUN=1).
- One sub-module, `insn_buf_ram`: `NUM_INSN`×`INSN_WIDTH`, one write port and one registered read port.

## Test plan
- Load frame: counter 0..15 with data `16'hA000+i` (data lags by one cycle), then `start`, then fetch pc 0..15 → `fetch_insn` = `16'hA000..16'hA00F`, each one cycle after its request.
- Handshake: `start` at cycle 10 → `ready` = 0 at 11; `core_done` at 20 → `ready` = 1 at 21.
- R0: `init_r0_en` = 1 with `init_r0` = `8'h5C` in READY, then `start` → `r0_value` = `8'h5C` and a single `r0_load` pulse at start+1. A second `start` without a new `init_r0_en` → no pulse.
- Write protection: in RUN, drive counter 3 with data `16'hFFFF` → fetch pc 3 still returns the loaded value.
- Error and collision cases:
  - `start` in RUN → `start_err` pulse, state unchanged.
  - `start` with `core_done` in READY → RUN.
  - `fetch_req` in READY → no `fetch_valid`.
- Reset mid-RUN with `fetch_req` pending → `ready` = 1 and `fetch_valid` = 0 next cycle.
- With `LOADER_PERF_CNT_EN`, 7 RUN cycles → `busy_cycles` = 7.
